// File: rtl/bcd2bin_seq.sv
// Sequential sign-magnitude BCD to two's-complement converter, one decimal
// digit per clock, most significant digit first, with start/busy/done handshake.
module bcd2bin_seq #(
    parameter int width  = 12,
    parameter int digits = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*digits-1:0]   bcd,
    input  logic                  neg,
    output logic [width-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // state | meaning
    // IDLE  | waiting for start; last result held on bin/err
    // ACC   | accumulating one digit per edge, cnt selects the digit
    // FIN   | result and error written, done pulsed
    typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

    localparam int AW = width + 4;
    localparam int CW = (digits > 1) ? $clog2(digits) : 1;
    localparam logic [AW-1:0] LIM_POS = AW'((64'd1 << (width - 1)) - 64'd1);
    localparam logic [AW-1:0] LIM_NEG = AW'(64'd1 << (width - 1));

    state_t                state_q, state_d;
    logic [4*digits-1:0]   bcd_q, bcd_d;
    logic                  neg_q, neg_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  inv_q, inv_d;
    logic [width-1:0]      bin_q, bin_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic                  nib_bad;
    logic [3:0]            digit;
    logic [AW-1:0]         acc_new;
    logic [AW-1:0]         acc_neg;
    logic [AW-1:0]         limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            inv_q   <= inv_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        inv_d   = inv_q;
        bin_d   = bin_q;
        err_d   = err_q;
        done_d  = 1'b0;

        nib_bad = 1'b0;
        digit   = 4'd0;
        for (int i = 0; i < digits; i++) begin
            if (bcd[4*i +: 4] > 4'd9) nib_bad = 1'b1;
            if (cnt_q == CW'(i)) digit = bcd_q[4*i +: 4];
        end
        acc_new = acc_q * AW'(10) + AW'(digit);
        acc_neg = -acc_q;
        limit   = neg_q ? LIM_NEG : LIM_POS;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bcd_d   = bcd;
                    neg_d   = neg;
                    inv_d   = nib_bad;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(digits - 1);
                    state_d = nib_bad ? FIN : ACC;
                end
            end
            ACC: begin
                // Once out of range the magnitude is frozen; the result is discarded anyway.
                if (!ovf_q) begin
                    acc_d = acc_new;
                    if (acc_new > limit) ovf_d = 1'b1;
                end
                if (cnt_q == '0) state_d = FIN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIN: begin
                err_d   = inv_q | ovf_q;
                if (inv_q | ovf_q) bin_d = '0;
                else if (neg_q)    bin_d = acc_neg[width-1:0];
                else               bin_d = acc_q[width-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bin  = bin_q;
    assign err  = err_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Randomized and directed bench for bcd2bin_seq against an arithmetic model.
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd = '0;
    logic        neg = 1'b0;
    logic [11:0] bin;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    bcd2bin_seq #(.width(12), .digits(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd), .neg(neg),
        .bin(bin), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal value by plain arithmetic, range check on the final magnitude.
    task automatic model(input logic [15:0] b, input logic n,
                         output logic [11:0] eb, output logic ee, output logic inv);
        int mag;
        logic [15:0] t;
        t   = b;
        inv = 1'b0;
        mag = 0;
        for (int k = 3; k >= 0; k--) begin
            int d;
            d = int'(t[4*k +: 4]);
            if (d > 9) inv = 1'b1;
            mag = mag * 10 + d;
        end
        if (inv || (n && mag > 2048) || (!n && mag > 2047)) begin
            ee = 1'b1;
            eb = 12'h000;
        end else begin
            ee = 1'b0;
            eb = n ? 12'(-mag) : 12'(mag);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int m);
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic convert(input logic [15:0] b, input logic n, input string tag);
        logic [11:0] eb;
        logic ee, inv;
        int cyc;
        model(b, n, eb, ee, inv);
        @(negedge clk);
        bcd = b; neg = n; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcd = 16'($urandom);
        neg = 1'($urandom);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({tag, "_busy"}, busy, 1'b1);
        end
        chk({tag, "_lat"}, cyc - 1, inv ? 1 : 5);
        chk({tag, "_bin"}, bin, eb);
        chk({tag, "_err"}, err, ee);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int ndone, last, prev;
        logic [11:0] gbin;

        #12;
        chk("rst_bin", bin, 12'h000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(16'h0123, 1'b0, "t0123");
        repeat (10) @(negedge clk);
        chk("t0123_hold", bin, 12'h07B);

        convert(16'h2048, 1'b1, "n2048");
        convert(16'h2048, 1'b0, "p2048");
        convert(16'h9999, 1'b1, "n9999");
        convert(16'h0A12, 1'b0, "inv0A12");
        convert(16'h0000, 1'b1, "negzero");

        // second start while busy must be ignored
        @(negedge clk);
        bcd = 16'h2047; neg = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bcd = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        gbin = '0;
        repeat (15) begin
            @(negedge clk);
            if (done) begin ndone++; gbin = bin; end
        end
        chk("ignore_cnt", ndone, 1);
        chk("ignore_bin", gbin, 12'h7FF);

        // async reset mid-accumulation
        @(negedge clk);
        bcd = 16'h0500; neg = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bin", bin, 12'h000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst_nodone", ndone, 0);
        convert(16'h0007, 1'b1, "n0007");

        // start held high: back-to-back conversions
        @(negedge clk);
        bcd = 16'h0010; neg = 1'b0; start = 1'b1;
        ndone = 0; last = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                chk("b2b_bin", bin, 12'h00A);
                if (last >= 0) chk("b2b_period", c - last, 6);
                last = c;
            end
        end
        chk("b2b_cnt", ndone >= 4, 1'b1);
        start = 1'b0;
        repeat (10) @(negedge clk);

        // random and range-boundary stimulus
        for (int i = 0; i < 40; i++) begin
            logic [15:0] b;
            prev = int'($urandom_range(0, 3));
            if (prev == 0) begin
                b = to_bcd(int'($urandom_range(2045, 2050)));
            end else begin
                b = '0;
                for (int k = 0; k < 4; k++)
                    b[4*k +: 4] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15))
                                                                : 4'($urandom_range(0, 9));
            end
            convert(b, 1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
